// File: rtl/seq_shifter_pkg.sv
// Shared types and the combinational shift kernel for seq_shifter.
//   shift_mode_t : shift flavour selected by the mode switches
//   DIR_LEFT/RIGHT : encoding of the latched direction bit
//   shift_step() : one shift step, returns {carry, result}
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    SH_LOGIC = 2'b00,
    SH_ROT   = 2'b01,
    SH_ARITH = 2'b10,
    SH_HOLD  = 2'b11
  } shift_mode_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // The kernel works on a fixed maximum container; callers zero-extend
  // their word and pass the live width. WIDTH of any instance must not
  // exceed SH_MAX_W.
  localparam int SH_MAX_W = 64;
  localparam int SH_IDX_W = $clog2(SH_MAX_W);

  // One step of `amt` positions. For a zero effective distance (or hold)
  // the word and carry_in pass through unchanged.
  function automatic logic [SH_MAX_W:0] shift_step(
    input logic [SH_MAX_W-1:0] word,
    input int                  width,
    input int                  amt,
    input logic                dir_left,
    input shift_mode_t         mode,
    input logic                carry_in
  );
    logic [SH_MAX_W-1:0] result;
    logic                carry;
    logic                sign;
    int                  n;
    int                  src;

    result = word;
    carry  = carry_in;
    sign   = word[SH_IDX_W'(width - 1)];
    n      = (mode == SH_ROT) ? (amt % width) : amt;

    if (mode != SH_HOLD && n != 0) begin
      result = '0;
      for (int i = 0; i < SH_MAX_W; i++) begin
        if (i < width) begin
          if (dir_left) begin
            src = i - n;
            if (mode == SH_ROT)
              result[i] = word[SH_IDX_W'((src + width) % width)];
            else
              result[i] = (src >= 0) ? word[SH_IDX_W'(src)] : 1'b0;
          end else begin
            src = i + n;
            if (mode == SH_ROT)
              result[i] = word[SH_IDX_W'(src % width)];
            else if (src < width)
              result[i] = word[SH_IDX_W'(src)];
            else
              result[i] = (mode == SH_ARITH) ? sign : 1'b0;
          end
        end
      end
      // Shifting by the full width or more leaves only fill bits, so the
      // last bit "out" is the fill bit itself. Rotate never gets here
      // because n was reduced modulo width.
      if (n >= width)
        carry = (!dir_left && mode == SH_ARITH) ? sign : 1'b0;
      else
        carry = dir_left ? word[SH_IDX_W'(width - n)] : word[SH_IDX_W'(n - 1)];
    end

    return {carry, result};
  endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Board-side bundle of seq_shifter: switches/buttons in, LED word out.
//   master : the board / bench (drives controls, observes word)
//   slave  : the shifter itself
interface seq_shifter_if #(
  parameter int WIDTH = 16
);
  localparam int AMT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]              load_val;
  logic                          btn_load;
  logic                          btn_left;
  logic                          btn_right;
  seq_shifter_pkg::shift_mode_t  mode;
  logic [AMT_W-1:0]              amt;
  logic                          auto_en;
  logic [WIDTH-1:0]              res;
  logic                          dir;
  logic                          carry_out;
  logic [15:0]                   step_cnt;

  modport master (
    output load_val, btn_load, btn_left, btn_right, mode, amt, auto_en,
    input  res, dir, carry_out, step_cnt
  );

  modport slave (
    input  load_val, btn_load, btn_left, btn_right, mode, amt, auto_en,
    output res, dir, carry_out, step_cnt
  );

endinterface

// File: rtl/seq_shifter_debounce_edge.sv
// Conditions one raw push button: 2-flop synchroniser, counter debounce,
// and a one-cycle pulse on each accepted rising level.
//   clock, reset : system clock, async active-high reset
//   raw          : button pin, asynchronous to clock
//   level        : debounced button level
//   press        : single-cycle pulse after level goes 0 -> 1
module debounce_edge #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DB_CYCLES-th consecutive disagreeing edge;
  // one agreeing sample restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1))
        db_d = ~db_q;
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value; with blocking '=' sync2_q would see the new sync1_q
  // and the synchroniser would collapse to a single stage.
  // NOTE: the synchroniser flops are reset too, so a raw sample captured
  // before reset can never mature into a press afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign level = db_q;
  assign press = db_q & ~db_dly_q;

endmodule

// File: rtl/seq_shifter.sv
// Registered WIDTH-bit shifter driven by board buttons and an auto-tick.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : load_val/btn_*/mode/amt/auto_en in,
//                  res/dir/carry_out/step_cnt out
// Events per cycle, highest first: load press, direction press, tick.
module seq_shifter #(
  parameter int WIDTH     = 16,
  parameter int DB_CYCLES = 1_000_000,
  parameter int TICK_DIV  = 10_000_000
) (
  input  logic          clock,
  input  logic          reset,
  seq_shifter_if.slave  bus
);
  import seq_shifter_pkg::*;

  localparam int PS_W = $clog2(TICK_DIV);

  logic load_press, left_press, right_press;
  logic load_level_unused, left_level_unused, right_level_unused;

  debounce_edge #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clock (clock),
    .reset (reset),
    .raw   (bus.btn_load),
    .level (load_level_unused),
    .press (load_press)
  );

  debounce_edge #(.DB_CYCLES(DB_CYCLES)) u_db_left (
    .clock (clock),
    .reset (reset),
    .raw   (bus.btn_left),
    .level (left_level_unused),
    .press (left_press)
  );

  debounce_edge #(.DB_CYCLES(DB_CYCLES)) u_db_right (
    .clock (clock),
    .reset (reset),
    .raw   (bus.btn_right),
    .level (right_level_unused),
    .press (right_press)
  );

  // ---------------------------------------------------------------------
  // Auto-step prescaler: free-runs only while auto_en is high.
  // ---------------------------------------------------------------------
  logic [PS_W-1:0] presc_q, presc_d;
  logic            tick;

  assign tick = bus.auto_en && (presc_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    presc_d = '0;
    if (bus.auto_en && !tick)
      presc_d = presc_q + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Shift datapath
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] res_q, res_d;
  logic             dir_q, dir_d;
  logic             carry_q, carry_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic             left_only, right_only;
  logic             step_left;
  logic [SH_MAX_W:0] step_out;

  assign left_only  = left_press & ~right_press;
  assign right_only = right_press & ~left_press;

  // A direction press steps in its own direction this very cycle; a tick
  // uses the latched one.
  assign step_left = left_only  ? DIR_LEFT  :
                     right_only ? DIR_RIGHT : dir_q;

  assign step_out = shift_step(SH_MAX_W'(res_q), WIDTH, int'(bus.amt),
                               step_left, bus.mode, carry_q);

  if (WIDTH < SH_MAX_W) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^step_out[SH_MAX_W-1:WIDTH];
  end

  // NOTE: every output of this block gets a default first; any path that
  // left one unassigned would infer a latch instead of a mux.
  always_comb begin
    logic do_step;
    res_d      = res_q;
    dir_d      = dir_q;
    carry_d    = carry_q;
    step_cnt_d = step_cnt_q;
    do_step    = 1'b0;

    if (load_press) begin
      res_d = bus.load_val;
    end else if (left_only) begin
      dir_d   = DIR_LEFT;
      do_step = 1'b1;
    end else if (right_only) begin
      dir_d   = DIR_RIGHT;
      do_step = 1'b1;
    end else if (!left_press && !right_press && tick) begin
      do_step = 1'b1;
    end

    // Hold mode still lets presses move dir, but freezes the word.
    if (do_step && bus.mode != SH_HOLD) begin
      res_d      = step_out[WIDTH-1:0];
      carry_d    = step_out[SH_MAX_W];
      step_cnt_d = step_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q      <= '0;
      dir_q      <= DIR_LEFT;
      carry_q    <= 1'b0;
      step_cnt_q <= '0;
      presc_q    <= '0;
    end else begin
      res_q      <= res_d;
      dir_q      <= dir_d;
      carry_q    <= carry_d;
      step_cnt_q <= step_cnt_d;
      presc_q    <= presc_d;
    end
  end

  assign bus.res       = res_q;
  assign bus.dir       = dir_q;
  assign bus.carry_out = carry_q;
  assign bus.step_cnt  = step_cnt_q;

endmodule
